// File: rtl/i3c_pkg.sv
// Shared constants and types for the I3C DAT/DCT memory arbiter slice.
// The lock feature (I3C_MEM_ARB_LOCK_EN) uses the lock state enum and counter width.
package i3c_pkg;

    localparam int DatDepth       = 16;
    localparam int MemArbLockCntW = 5;

    typedef enum logic {
        PortA = 1'b0,
        PortB = 1'b1
    } mem_arb_port_e;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StLockedA = 2'd1,
        StLockedB = 2'd2
    } mem_arb_lock_e;

endpackage

// File: rtl/i3c_rr_arb2.sv
// Two-way round-robin grant with the last-granted register.
// Reset leaves last_q on port B, so port A wins the first conflict.
module i3c_rr_arb2
    import i3c_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    mem_arb_port_e last_q;

    always_comb begin
        gnt_a = req_a && (!req_b || last_q == PortB);
        gnt_b = req_b && !gnt_a;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= PortB;
        end else if (gnt_a) begin
            last_q <= PortA;
        end else if (gnt_b) begin
            last_q <= PortB;
        end
    end

endmodule

// File: rtl/i3c_mem_arbiter.sv
// Shares one single-port DAT/DCT memory (1-cycle read latency) between the CSR path (A)
// and the command engine (B). Optional bus lock is enabled with I3C_MEM_ARB_LOCK_EN.
module i3c_mem_arbiter
    import i3c_pkg::*;
#(
    parameter int  Depth           = DatDepth,
    parameter int  Width           = 64,
    parameter int  DataBitsPerMask = 32,
    parameter int  LockTimeout     = 16,
    localparam int Aw              = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_i,
`ifdef I3C_MEM_ARB_LOCK_EN
    input  logic             a_lock_i,
    input  logic             b_lock_i,
`endif
    input  logic             a_req_i,
    output logic             a_gnt_o,
    input  logic             a_write_i,
    input  logic [Aw-1:0]    a_addr_i,
    input  logic [Width-1:0] a_wdata_i,
    input  logic [Width-1:0] a_wmask_i,
    output logic [Width-1:0] a_rdata_o,
    output logic             a_rvalid_o,
    output logic [1:0]       a_rerror_o,
    input  logic             b_req_i,
    output logic             b_gnt_o,
    input  logic             b_write_i,
    input  logic [Aw-1:0]    b_addr_i,
    input  logic [Width-1:0] b_wdata_i,
    input  logic [Width-1:0] b_wmask_i,
    output logic [Width-1:0] b_rdata_o,
    output logic             b_rvalid_o,
    output logic [1:0]       b_rerror_o,
    output logic             mem_req_o,
    output logic             mem_write_o,
    output logic [Aw-1:0]    mem_addr_o,
    output logic [Width-1:0] mem_wdata_o,
    output logic [Width-1:0] mem_wmask_o,
    input  logic [Width-1:0] mem_rdata_i,
    input  logic [1:0]       mem_rerror_i
);

    if (Width % DataBitsPerMask != 0 || LockTimeout < 1 ||
        LockTimeout >= (1 << MemArbLockCntW)) begin : g_bad_cfg
        $error("i3c_mem_arbiter: unsupported parameter combination");
    end

    // Request bundle sized by this instance's Aw/Width.
    typedef struct packed {
        logic             req;
        logic             write;
        logic [Aw-1:0]    addr;
        logic [Width-1:0] wdata;
        logic [Width-1:0] wmask;
    } mem_arb_req_t;

    mem_arb_req_t  a_port, b_port, sel;
    logic          allow_a, allow_b;
    logic          req_a, req_b, gnt_a, gnt_b;
    logic          rv_read_q;
    mem_arb_port_e rv_port_q;

    assign a_port = '{req: a_req_i, write: a_write_i, addr: a_addr_i,
                      wdata: a_wdata_i, wmask: a_wmask_i};
    assign b_port = '{req: b_req_i, write: b_write_i, addr: b_addr_i,
                      wdata: b_wdata_i, wmask: b_wmask_i};

`ifdef I3C_MEM_ARB_LOCK_EN
    mem_arb_lock_e             state_q;
    logic [MemArbLockCntW-1:0] lock_cnt_q;
    logic                      hold;

    // The owner keeps the lock only while it asserts lock_i and the timeout has not hit.
    assign hold = ((state_q == StLockedA && a_lock_i) ||
                   (state_q == StLockedB && b_lock_i)) &&
                  (lock_cnt_q != MemArbLockCntW'(LockTimeout));
    assign allow_a = !(hold && state_q == StLockedB);
    assign allow_b = !(hold && state_q == StLockedA);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            lock_cnt_q <= '0;
        end else if (hold) begin
            lock_cnt_q <= lock_cnt_q + 1'b1;
        end else if (gnt_a && a_lock_i) begin
            state_q    <= StLockedA;
            lock_cnt_q <= '0;
        end else if (gnt_b && b_lock_i) begin
            state_q    <= StLockedB;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= StIdle;
            lock_cnt_q <= '0;
        end
    end
`else
    assign allow_a = 1'b1;
    assign allow_b = 1'b1;
`endif

    assign req_a = a_req_i && allow_a && !rst_i;
    assign req_b = b_req_i && allow_b && !rst_i;

    i3c_rr_arb2 u_rr (
        .clk   (clk_i),
        .rst   (rst_i),
        .req_a (req_a),
        .req_b (req_b),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );

    assign a_gnt_o = gnt_a;
    assign b_gnt_o = gnt_b;

    always_comb begin
        sel = '0;
        if (gnt_a) begin
            sel = a_port;
        end else if (gnt_b) begin
            sel = b_port;
        end
    end

    assign mem_req_o   = sel.req;
    assign mem_write_o = sel.write;
    assign mem_addr_o  = sel.addr;
    assign mem_wdata_o = sel.wdata;
    assign mem_wmask_o = sel.wmask;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rv_read_q <= 1'b0;
            rv_port_q <= PortA;
        end else begin
            rv_read_q <= (gnt_a && !a_write_i) || (gnt_b && !b_write_i);
            rv_port_q <= gnt_b ? PortB : PortA;
        end
    end

    // Gating with rst_i drops a read granted in the cycle just before reset.
    assign a_rvalid_o = rv_read_q && rv_port_q == PortA && !rst_i;
    assign b_rvalid_o = rv_read_q && rv_port_q == PortB && !rst_i;
    assign a_rdata_o  = a_rvalid_o ? mem_rdata_i  : '0;
    assign a_rerror_o = a_rvalid_o ? mem_rerror_i : '0;
    assign b_rdata_o  = b_rvalid_o ? mem_rdata_i  : '0;
    assign b_rerror_o = b_rvalid_o ? mem_rerror_i : '0;

endmodule
